// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two requesters.
// Optional ALU_ARB_STATS_EN adds saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   rr_ptr;
   logic   cur_id;
   logic   grant_vld;
   logic   grant_id;

   // Grant selection; only meaningful in IDLE, so a grant always implies a handshake.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      req_ready = 2'b00;
      if (state == IDLE) begin
         unique case (req_valid)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;   end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;   end
            2'b11:   begin grant_vld = 1'b1; grant_id = rr_ptr; end
            default: begin grant_vld = 1'b0; grant_id = 1'b0;   end
         endcase
      end
      if (grant_vld) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // Control FSM with registered ALU drive and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         cur_id    <= 1'b0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_y     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_vld) begin
                  alu_op <= grant_id ? req1_op : req0_op;
                  alu_a  <= grant_id ? req1_a  : req0_a;
                  alu_b  <= grant_id ? req1_b  : req0_b;
                  cur_id <= grant_id;
                  rr_ptr <= ~grant_id;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_y     <= alu_y;
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Saturating grant counters, bumped on each request handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (grant_vld) begin
         if (!grant_id && grant_cnt0 != CNT_MAX) begin
            grant_cnt0 <= grant_cnt0 + 16'(1);
         end
         if (grant_id && grant_cnt1 != CNT_MAX) begin
            grant_cnt1 <= grant_cnt1 + 16'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; a small model ALU drives alu_y.
module tb_alu_arbiter;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned OPW   = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [OPW-1:0]   req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_y;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_y;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]      grant_cnt0, grant_cnt1;
`endif

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   always #5 clk = ~clk;

   // Model ALU slice sitting on the shared datapath.
   function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a ^ b;
         3'd4:    return a - b;
         3'd5:    return ~a;
         3'd6:    return b;
         default: return a;
      endcase
   endfunction

   assign alu_y = alu_f(alu_op, alu_a, alu_b);

   int checks = 0;
   int errors = 0;

   // Reference model: one outstanding transaction, age counted in cycles since acceptance.
   bit               m_pend;
   int               m_age;
   bit               m_id;
   bit               m_prio;
   logic [OPW-1:0]   m_op;
   logic [WIDTH-1:0] m_a, m_b, m_y;
   int               m_gcnt [2];
   bit               served [$];
   logic [WIDTH-1:0] last_y;
   int               rv_cnt;
   logic [1:0]       auto_drop;
   bit               rand_mode;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_age = 0; m_prio = 0;
      m_gcnt[0] = 0; m_gcnt[1] = 0;
   endtask

   task automatic new_req(input int i);
      if (i == 0) begin
         req0_op = OPW'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
      end else begin
         req1_op = OPW'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
      end
   endtask

   // One clock cycle: check outputs against the model, cross the edge, advance the model.
   task automatic cyc();
      logic [1:0] exp_rdy;
      bit         gid, grant, rsp_hs, exp_rv;
      #1;
      exp_rdy = 2'b00; gid = 0; grant = 0;
      if (!m_pend && req_valid != 2'b00) begin
         grant = 1;
         gid   = (req_valid == 2'b11) ? m_prio : req_valid[1];
         exp_rdy[gid] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      exp_rv = m_pend && m_age >= 2;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("rsp_id", 64'(rsp_id), 64'(m_id));
         chk("rsp_y", 64'(rsp_y), 64'(m_y));
      end
      if (m_pend) begin
         chk("alu_op", 64'(alu_op), 64'(m_op));
         chk("alu_a", 64'(alu_a), 64'(m_a));
         chk("alu_b", 64'(alu_b), 64'(m_b));
      end
      if (rsp_valid) rv_cnt++;
      rsp_hs = rsp_valid && rsp_ready;
      if (rsp_hs) last_y = rsp_y;
      @(posedge clk);
      if (grant) begin
         m_pend = 1; m_age = 1; m_id = gid; m_prio = ~gid;
         m_op = gid ? req1_op : req0_op;
         m_a  = gid ? req1_a  : req0_a;
         m_b  = gid ? req1_b  : req0_b;
         m_y  = alu_f(m_op, m_a, m_b);
         if (m_gcnt[gid] < 16'hFFFF) m_gcnt[gid]++;
      end else if (m_pend) begin
         if (exp_rv && rsp_hs) begin
            m_pend = 0;
            served.push_back(m_id);
         end else begin
            m_age++;
         end
      end
      #1;
      if (grant && auto_drop[gid]) begin
         req_valid[gid] = 1'b0;
         if (rand_mode) new_req(int'(gid));
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      @(posedge clk); #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_y", 64'(rsp_y), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_b", 64'(alu_b), 64'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      auto_drop = 2'b11; rand_mode = 0; rv_cnt = 0; last_y = '0;
      @(posedge clk); #1;
      apply_reset();

      // Reset mid-EXEC abandons the operation.
      req0_op = 3'b000; req0_a = 32'hFFFFFFFF; req0_b = 32'h771FFE01;
      req_valid = 2'b01;
      cyc();
      rst_n = 1'b0;
      #1;
      chk("midexec_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midexec_alu_a", 64'(alu_a), 64'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      served.delete(); rv_cnt = 0;
      repeat (5) cyc();
      chk("midexec_no_rsp", 64'(rv_cnt), 64'd0);

      // Single requester, AND.
      served.delete(); rv_cnt = 0;
      req_valid = 2'b01;
      repeat (6) cyc();
      chk("single_count", 64'(served.size()), 64'd1);
      if (served.size() > 0) chk("single_id", 64'(served[0]), 64'd0);
      chk("single_y", 64'(last_y), 64'h771FFE01);
      chk("single_width", 64'(rv_cnt), 64'd1);

      // Contention right after reset: requester 0 first.
      apply_reset();
      served.delete();
      req1_op = 3'b000; req1_a = 32'hC15DF831; req1_b = 32'hFE7BF557;
      req_valid = 2'b11;
      repeat (8) cyc();
      chk("cont_count", 64'(served.size()), 64'd2);
      if (served.size() == 2) begin
         chk("cont_first", 64'(served[0]), 64'd0);
         chk("cont_second", 64'(served[1]), 64'd1);
      end
      chk("cont_y", 64'(last_y), 64'hC059F011);

      // Round-robin with both requesters continuously valid.
      served.delete(); auto_drop = 2'b00; req_valid = 2'b11;
      for (int n = 0; n < 40 && served.size() < 6; n++) cyc();
      req_valid = 2'b00;
      cyc();
      chk("rr_count", 64'(served.size()), 64'd6);
      foreach (served[k]) chk($sformatf("rr_seq%0d", k), 64'(served[k]), 64'(k % 2));

      // Response backpressure, with requester 1 waiting.
      auto_drop = 2'b11; rsp_ready = 1'b0;
      req0_op = 3'b000; req0_a = 32'h03AF5554; req0_b = 32'h00000000;
      req_valid = 2'b11;
      for (int n = 0; n < 10 && !(m_pend && m_age >= 2); n++) cyc();
      chk("bp_reached_resp", 64'(m_pend && m_age >= 2), 64'd1);
      repeat (10) cyc();
      chk("bp_rsp_y", 64'(rsp_y), 64'd0);
      rsp_ready = 1'b1;
      cyc();
      #1;
      chk("bp_next_grant", 64'(req_ready), 64'b10);
      repeat (5) cyc();

      // Randomized traffic with random response backpressure.
      rand_mode = 1; new_req(0); new_req(1);
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      rand_mode = 0; req_valid = 2'b00; rsp_ready = 1'b1;
      repeat (4) cyc();

`ifdef ALU_ARB_STATS_EN
      // Grant counters: 3 grants to requester 0, 2 to requester 1, then saturation.
      apply_reset();
      served.delete(); auto_drop = 2'b00; req_valid = 2'b11;
      for (int n = 0; n < 40 && served.size() < 5; n++) cyc();
      req_valid = 2'b00;
      cyc();
      chk("stats_cnt0", 64'(grant_cnt0), 64'd3);
      chk("stats_cnt1", 64'(grant_cnt1), 64'd2);
      force dut.grant_cnt0 = 16'hFFFF;
      #1;
      release dut.grant_cnt0;
      req_valid = 2'b01; auto_drop = 2'b11;
      repeat (4) cyc();
      chk("stats_sat", 64'(grant_cnt0), 64'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
